// File: rtl/spi_slave_gen_if.sv
// Serial and parallel signals of the SPI slave front end, bundled per direction.
// slave modport is the front end itself; master modport is the host/bench side.
interface spi_slave_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH+1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  busy;
  logic                  frame_err;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid, busy, frame_err
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_gen.sv
// SPI slave front end: deserialises {cmd, payload} from mosi (one bit per clk) and, for
// read-data commands, shifts a response word onto a registered miso; ss_n frames everything.
module spi_slave_gen #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_gen_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] ALL_BITS = CW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, CMD, RX, DONE, RD_WAIT, TX} state_t;

  state_t                state_q, state_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH+1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  miso_q, miso_d;

  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_first;
  logic                  tx_next;

  // Bit-order steering: the shift registers always move toward the "first" end.
  always_comb begin
    if (MSB_FIRST) begin
      rx_shift = {rx_sr_q[DATA_WIDTH-2:0], bus.mosi};
      tx_shift = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
      tx_first = bus.tx_data[DATA_WIDTH-1];
      tx_next  = tx_sr_q[DATA_WIDTH-2];
    end else begin
      rx_shift = {bus.mosi, rx_sr_q[DATA_WIDTH-1:1]};
      tx_shift = {1'b0, tx_sr_q[DATA_WIDTH-1:1]};
      tx_first = bus.tx_data[0];
      tx_next  = tx_sr_q[1];
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.ss_n) begin
          cmd_d   = {bus.mosi, 1'b0};
          state_d = CMD;
        end
      end
      CMD: begin
        if (bus.ss_n) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cmd_d   = {cmd_q[1], bus.mosi};
          cnt_d   = '0;
          state_d = RX;
        end
      end
      RX: begin
        if (bus.ss_n) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          rx_sr_d = rx_shift;
          if (cnt_q == LAST_BIT) begin
            rx_data_d  = {cmd_q, rx_shift};
            rx_valid_d = 1'b1;
            state_d    = (cmd_q == 2'b11) ? RD_WAIT : DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.ss_n) begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        // ss_n high wins over a simultaneous tx_valid.
        if (bus.ss_n) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (bus.tx_valid) begin
          tx_sr_d = bus.tx_data;
          miso_d  = tx_first;
          cnt_d   = CW'(1);
          state_d = TX;
        end
      end
      TX: begin
        // cnt_q counts bits already presented; once all are out the frame is complete.
        if (cnt_q == ALL_BITS) begin
          state_d = DONE;
        end else if (bus.ss_n) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          tx_sr_d = tx_shift;
          miso_d  = tx_next;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
